// File: rtl/rx_bit_timer_if.sv
// Handshake bundle between the receive controller and the receive bit timer.
// The controller drives enable/resync; the timer returns strobes and frame status.
interface rx_bit_timer_if #(
  parameter int unsigned BITS_PER_FRAME = 9
);
  localparam int unsigned BW = $clog2(BITS_PER_FRAME + 1);

  logic          enable_timer;
  logic          resync;
  logic          shift_strobe;
  logic          packet_done;
  logic [BW-1:0] bit_count;
  logic          timer_active;

  modport master (
    output enable_timer, resync,
    input  shift_strobe, packet_done, bit_count, timer_active
  );

  modport slave (
    input  enable_timer, resync,
    output shift_strobe, packet_done, bit_count, timer_active
  );
endinterface

// File: rtl/rx_bit_timer.sv
// Receive bit timer: paces mid-bit sampling strobes after a start edge, counts
// sampled bits and pulses packet_done once the last bit of the frame is taken.
module rx_bit_timer #(
  parameter int unsigned CLKS_PER_BIT   = 10,
  parameter int unsigned SAMPLE_PT      = 5,
  parameter int unsigned BITS_PER_FRAME = 9
) (
  input logic          clk,
  input logic          n_rst,
  rx_bit_timer_if.slave bus
);
  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BW = $clog2(BITS_PER_FRAME + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_clk_cnt;
  logic [BW-1:0] r_bit_cnt;
  logic          w_strobe;
  logic          w_last_bit;
  logic          w_wrap;

  // Strobe is gated by enable in the same cycle so an abort never samples.
  assign w_strobe   = (r_state == ACTIVE) && bus.enable_timer &&
                      (r_clk_cnt == CW'(SAMPLE_PT));
  assign w_last_bit = (r_bit_cnt == BW'(BITS_PER_FRAME - 1));
  assign w_wrap     = (r_clk_cnt == CW'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state   <= IDLE;
      r_clk_cnt <= '0;
      r_bit_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_bit_cnt <= '0;
          if (bus.enable_timer) begin
            r_state   <= ACTIVE;
            r_clk_cnt <= CW'(1);
          end else begin
            r_clk_cnt <= '0;
          end
        end
        ACTIVE: begin
          if (!bus.enable_timer) begin
            r_state   <= IDLE;
            r_clk_cnt <= '0;
            r_bit_cnt <= '0;
          end else if (w_strobe && w_last_bit) begin
            r_state   <= DONE;
            r_clk_cnt <= '0;
            r_bit_cnt <= BW'(BITS_PER_FRAME);
          end else begin
            if (w_strobe) begin
              r_bit_cnt <= r_bit_cnt + BW'(1);
            end
            // Resync realigns phase so the next strobe lands SAMPLE_PT-1 edges later.
            if (bus.resync) begin
              r_clk_cnt <= CW'(1);
            end else if (w_wrap) begin
              r_clk_cnt <= '0;
            end else begin
              r_clk_cnt <= r_clk_cnt + CW'(1);
            end
          end
        end
        DONE: begin
          r_state   <= IDLE;
          r_clk_cnt <= '0;
          r_bit_cnt <= '0;
        end
        default: begin
          r_state   <= IDLE;
          r_clk_cnt <= '0;
          r_bit_cnt <= '0;
        end
      endcase
    end
  end

  assign bus.shift_strobe = w_strobe;
  assign bus.packet_done  = (r_state == DONE);
  assign bus.bit_count    = r_bit_cnt;
  assign bus.timer_active = (r_state == ACTIVE);

endmodule

// File: tb/tb_rx_bit_timer.sv
// Directed bench for rx_bit_timer: default instance plus a short-frame instance
// (CLKS_PER_BIT=4, SAMPLE_PT=2, BITS_PER_FRAME=2), hand-computed strobe timing.
module tb_rx_bit_timer;
  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  int unsigned total = 0;
  int unsigned bad = 0;

  always #5 clk = ~clk;

  rx_bit_timer_if #(.BITS_PER_FRAME(9)) bus_a ();
  rx_bit_timer_if #(.BITS_PER_FRAME(2)) bus_b ();

  rx_bit_timer #(.CLKS_PER_BIT(10), .SAMPLE_PT(5), .BITS_PER_FRAME(9)) dut_a (
    .clk(clk), .n_rst(n_rst), .bus(bus_a)
  );
  rx_bit_timer #(.CLKS_PER_BIT(4), .SAMPLE_PT(2), .BITS_PER_FRAME(2)) dut_b (
    .clk(clk), .n_rst(n_rst), .bus(bus_b)
  );

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit which, input bit en, input bit rs);
    if (which) begin
      bus_b.enable_timer = en;
      bus_b.resync       = rs;
    end else begin
      bus_a.enable_timer = en;
      bus_a.resync       = rs;
    end
  endtask

  task automatic sample(input bit which, output bit s, output bit p,
                        output int unsigned bc, output bit a);
    if (which) begin
      s = bus_b.shift_strobe; p = bus_b.packet_done;
      bc = int'(bus_b.bit_count); a = bus_b.timer_active;
    end else begin
      s = bus_a.shift_strobe; p = bus_a.packet_done;
      bc = int'(bus_a.bit_count); a = bus_a.timer_active;
    end
  endtask

  task automatic check_all(input string tag, input bit which, input bit es,
                           input bit ep, input int unsigned eb, input bit ea);
    bit s, p, a;
    int unsigned bc;
    sample(which, s, p, bc, a);
    chk({tag, " strobe"}, s, es);
    chk({tag, " done"},   p, ep);
    chk({tag, " bitcnt"}, bc, eb);
    chk({tag, " active"}, a, ea);
  endtask

  // Run one frame from IDLE. exp_str lists the edges (relative to E0) after which
  // a strobe cycle is expected; unused entries are negative-large sentinels.
  task automatic frame(input string tag, input bit which, input int rs_at,
                       input int exp_str[9], input int exp_done, input bit keep_en);
    bit es;
    int unsigned eb;
    drive(which, 1'b1, 1'b0);
    for (int n = 0; n <= exp_done + 1; n++) begin
      step();
      drive(which, 1'b1, n == rs_at);
      es = 1'b0;
      eb = 0;
      foreach (exp_str[i]) begin
        if (exp_str[i] == n) es = 1'b1;
        if (exp_str[i] >= 0 && exp_str[i] < n) eb++;
      end
      if (n == exp_done + 1) eb = 0;
      check_all($sformatf("%s e%0d", tag, n), which, es, n == exp_done, eb, n < exp_done);
    end
    if (!keep_en) drive(which, 1'b0, 1'b0);
  endtask

  int exp_str[9];

  initial begin
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b0);

    // Reset held with enable high and resync toggling: everything stays at zero.
    for (int i = 0; i < 6; i++) begin
      step();
      drive(1'b0, 1'b1, i[0]);
      drive(1'b1, 1'b1, i[0]);
      check_all($sformatf("rst a%0d", i), 1'b0, 1'b0, 1'b0, 0, 1'b0);
      check_all($sformatf("rst b%0d", i), 1'b1, 1'b0, 1'b0, 0, 1'b0);
    end
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    step();
    n_rst = 1'b1;
    step();

    // Full default frame, enable held through packet_done to observe the restart.
    exp_str = '{4, 14, 24, 34, 44, 54, 64, 74, 84};
    frame("full", 1'b0, -1, exp_str, 85, 1'b1);
    step();
    check_all("restart e87", 1'b0, 1'b0, 1'b0, 0, 1'b1);
    drive(1'b0, 1'b0, 1'b0);
    step();
    check_all("restart drop", 1'b0, 1'b0, 1'b0, 0, 1'b0);

    // Abort: drop enable in the 4th strobe cycle, so the strobe must be gated.
    drive(1'b0, 1'b1, 1'b0);
    for (int n = 0; n <= 34; n++) step();
    check_all("abort pre", 1'b0, 1'b1, 1'b0, 3, 1'b1);
    drive(1'b0, 1'b0, 1'b0);
    #1;
    check_all("abort gate", 1'b0, 1'b0, 1'b0, 3, 1'b1);
    for (int n = 0; n < 15; n++) begin
      step();
      check_all($sformatf("abort post%0d", n), 1'b0, 1'b0, 1'b0, 0, 1'b0);
    end

    // Resync at clk_cnt=8 during bit 2: sampled at E0+18, next strobe after E0+22.
    exp_str = '{4, 14, 22, 32, 42, 52, 62, 72, 82};
    frame("rsync8", 1'b0, 17, exp_str, 83, 1'b0);

    // Resync in the strobe cycle after E0+14: strobe counts, next after E0+19.
    exp_str = '{4, 14, 19, 29, 39, 49, 59, 69, 79};
    frame("rsyncstb", 1'b0, 14, exp_str, 80, 1'b0);

    // Async reset mid-frame with bit_count=5, applied between clock edges.
    drive(1'b0, 1'b1, 1'b0);
    for (int n = 0; n <= 47; n++) step();
    check_all("arst pre", 1'b0, 1'b0, 1'b0, 5, 1'b1);
    #2;
    n_rst = 1'b0;
    #1;
    check_all("arst now", 1'b0, 1'b0, 1'b0, 0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    step();
    step();
    n_rst = 1'b1;
    step();
    exp_str = '{4, 14, 24, 34, 44, 54, 64, 74, 84};
    frame("arst again", 1'b0, -1, exp_str, 85, 1'b0);

    // Short-frame instance.
    drive(1'b1, 1'b0, 1'b0);
    step();
    exp_str = '{1, 5, -100, -100, -100, -100, -100, -100, -100};
    frame("short", 1'b1, -1, exp_str, 6, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rx_bit_timer.md
# rx_bit_timer

Receive-side bit timer for the serial link. It is the counterpart of the transmit bit timer. Once the receive controller raises `enable_timer` on a detected start edge, the block paces bit sampling with a mid-bit `shift_strobe`, counts sampled bits, and flags the end of the frame with `packet_done`. A `resync` input lets the edge detector realign the bit phase on every data transition.

## Interface
- `CLKS_PER_BIT`, default 10: clock cycles per bit period; legal values ≥ 2.
- `SAMPLE_PT`, default 5: phase within the bit at which `shift_strobe` fires; legal values 1..`CLKS_PER_BIT`-1.
- `BITS_PER_FRAME`, default 9: bits sampled per frame (8 data + stop); legal values ≥ 1.
- `clk`  in  1  system clock, rising-edge.
- `n_rst`  in  1  reset, asynchronous, active-low.
- `enable_timer`  in  1  held high by the receive controller for the whole frame; low clears the timer.
- `resync`  in  1  one-cycle pulse on a line transition; realigns the bit phase.
- `shift_strobe`  out  1  one-cycle pulse; the receive shift register samples the line this cycle.
- `packet_done`  out  1  one-cycle pulse; the frame's last bit has been sampled.
- `bit_count`  out  $clog2(`BITS_PER_FRAME`+1)  number of bits sampled so far in the current frame.
- `timer_active`  out  1  high while state is ACTIVE.

## Operation
- Internal registers: `state` (IDLE, ACTIVE, DONE), `clk_cnt` (0..`CLKS_PER_BIT`-1), `bit_cnt`.
- Reset: `state`=IDLE, `clk_cnt`=0, `bit_cnt`=0. All outputs are 0.
- IDLE:
  - `clk_cnt`=0 and `bit_cnt`=0.
  - On a clock edge with `enable_timer`=1, go to ACTIVE and load `clk_cnt`=1.
- ACTIVE with `enable_timer`=1:
  - `clk_cnt` increments each cycle and wraps from `CLKS_PER_BIT`-1 to 0.
  - If `resync`=1, `clk_cnt` loads 1 instead. `resync` takes priority over the increment and wrap.
- `shift_strobe` is combinational: high when `state`=ACTIVE, `enable_timer`=1 and `clk_cnt`=`SAMPLE_PT`.
- At the edge ending a strobe cycle, `bit_cnt` increments.
  - If `bit_cnt` was `BITS_PER_FRAME`-1, the next state is DONE, `bit_cnt` becomes `BITS_PER_FRAME`, and `clk_cnt` clears.
- A strobe and a `resync` in the same cycle are both honoured: the strobe fires, `bit_cnt` advances, and `clk_cnt` loads 1.
- `enable_timer`=0 while in ACTIVE: the next state is IDLE and both counters clear. No strobe fires in that cycle.
- DONE:
  - `packet_done`=1 (combinational on state). `bit_count` holds `BITS_PER_FRAME`.
  - Next state is IDLE unconditionally, regardless of `enable_timer`, and counters clear.
- A new frame starts from IDLE whenever `enable_timer` is high. The controller must drop `enable_timer` on `packet_done` if it does not want an immediate restart.
- `bit_count` = `bit_cnt`. `timer_active` = (`state`==ACTIVE).
- `resync` has no effect in IDLE or DONE.

## Timing
- Let E0 be the first rising edge that samples `enable_timer`=1 in IDLE.
- Strobe k (k = 0..`BITS_PER_FRAME`-1) occupies the cycle after edge E0 + (`SAMPLE_PT`-1) + k·`CLKS_PER_BIT`, assuming no `resync`.
- `packet_done` occupies the cycle after the edge that ends the last strobe cycle. Edge E0+85 with defaults.
- The edge after that returns the block to IDLE. The earliest restart is the following edge.
- `resync` sampled at edge R: the next strobe occupies the cycle after edge R + `SAMPLE_PT`-1.
- Deasserting `enable_timer` gates `shift_strobe` in the same cycle (combinational). `timer_active` falls after the next edge.
- Asserting `n_rst` mid-frame clears all state and outputs immediately, without waiting for a clock edge.

## Test plan
- Reset check: hold `n_rst`=0 with `enable_timer`=1 and toggle `resync` -> all outputs remain 0.
- Full frame, defaults, `enable_timer` held high from E0:
  - 9 strobes occupy the cycles after E0+4, E0+14, …, E0+84.
  - `bit_count` steps 1..9.
  - `packet_done`=1 only in the cycle after E0+85.
  - IDLE after E0+86, and a new frame restarts at edge E0+87.
- Abort: drop `enable_timer` after the 3rd strobe -> no further strobes, `bit_count`=0 and `timer_active`=0 after the next edge, and no `packet_done`.
- Resync:
  - Pulse `resync` at `clk_cnt`=8 during bit 2 (edge R) -> next strobe in the cycle after R+4, and the later strobes are spaced 10 cycles apart.
  - Pulse `resync` in a strobe cycle -> the strobe still counts, and the next strobe occurs 4 edges after R.
- Async reset mid-frame: assert `n_rst` between clock edges while `bit_count`=5 -> outputs clear immediately, and the block restarts cleanly on re-enable.
- Non-default parameters `CLKS_PER_BIT`=4, `SAMPLE_PT`=2, `BITS_PER_FRAME`=2 -> strobes in the cycles after E0+1 and E0+5, and `packet_done` in the cycle after E0+6.
